// File: rtl/axil_reg_resp.sv
// AXI4-Lite slave holding NREG 32-bit configuration registers; register 0 reads as a fixed
// version constant. One transaction in flight per channel, response valid one cycle after accept.
module axil_reg_resp #(
    parameter int          AWIDTH  = 32,
    parameter int          DWIDTH  = 32,
    parameter int          SWIDTH  = 4,
    parameter int          NREG    = 16,
    parameter logic [31:0] VERSION = 32'h2017_0001
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [AWIDTH-1:0]      awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [DWIDTH-1:0]      wdata,
    input  logic [SWIDTH-1:0]      wstrb,
    output logic                   bvalid,
    input  logic                   bready,
    output logic [1:0]             bresp,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [AWIDTH-1:0]      araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [DWIDTH-1:0]      rdata,
    output logic [1:0]             rresp,
    output logic [NREG*DWIDTH-1:0] cfg_regs,
    output logic [NREG-1:0]        cfg_wr_pulse
);
    localparam int         IW          = $clog2(NREG);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    w_state_t          w_state_r;
    w_state_t          w_state_next_s;
    r_state_t          r_state_r;
    r_state_t          r_state_next_s;
    logic              wr_accept_s;
    logic              rd_accept_s;
    logic              wr_apply_s;
    logic              rd_in_range_s;
    logic [IW-1:0]     wr_idx_s;
    logic [IW-1:0]     rd_idx_s;
    logic [DWIDTH-1:0] regs_r [1:NREG-1];
    logic [DWIDTH-1:0] view_s [0:NREG-1];
    logic [1:0]        bresp_r;
    logic [1:0]        rresp_r;
    logic [DWIDTH-1:0] rdata_r;
    logic [NREG-1:0]   wr_pulse_r;
    logic              unused_s;

    function automatic logic addr_in_range(input logic [AWIDTH-1:0] addr);
        return (addr >> (IW + 2)) == {AWIDTH{1'b0}};
    endfunction

    assign wr_idx_s      = awaddr[IW+1:2];
    assign rd_idx_s      = araddr[IW+1:2];
    assign wr_apply_s    = addr_in_range(awaddr) && (wr_idx_s != {IW{1'b0}});
    assign rd_in_range_s = addr_in_range(araddr);
    assign unused_s      = ^{awaddr[1:0], araddr[1:0]};

    // Register view: slot 0 is the version constant, independent of reset.
    always_comb begin
        view_s[0] = VERSION;
        for (int i = 1; i < NREG; i++) begin
            view_s[i] = regs_r[i];
        end
    end

    // Flatten the register view onto the configuration bus.
    always_comb begin
        cfg_regs = {(NREG*DWIDTH){1'b0}};
        for (int i = 0; i < NREG; i++) begin
            cfg_regs[i*DWIDTH +: DWIDTH] = view_s[i];
        end
    end

    // Write FSM next state; AW and W are only taken together, never one alone.
    always_comb begin
        w_state_next_s = w_state_r;
        wr_accept_s    = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (!rst && awvalid && wvalid) begin
                    wr_accept_s    = 1'b1;
                    w_state_next_s = W_RESP;
                end else begin
                    w_state_next_s = W_IDLE;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_next_s = W_IDLE;
                end else begin
                    w_state_next_s = W_RESP;
                end
            end
            default: w_state_next_s = W_IDLE;
        endcase
    end

    // Write FSM state, response code and per-register write pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_r  <= W_IDLE;
            bresp_r    <= RESP_OKAY;
            wr_pulse_r <= {NREG{1'b0}};
        end else begin
            w_state_r  <= w_state_next_s;
            wr_pulse_r <= {NREG{1'b0}};
            if (wr_accept_s) begin
                bresp_r <= wr_apply_s ? RESP_OKAY : RESP_SLVERR;
                if (wr_apply_s) begin
                    wr_pulse_r[wr_idx_s] <= 1'b1;
                end
            end
        end
    end

    // Register storage with byte-lane strobes; index 0 has no storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_r[i] <= {DWIDTH{1'b0}};
            end
        end else if (wr_accept_s && wr_apply_s) begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_idx_s == IW'(i)) begin
                    for (int k = 0; k < SWIDTH; k++) begin
                        if (wstrb[k]) begin
                            regs_r[i][8*k +: 8] <= wdata[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        r_state_next_s = r_state_r;
        rd_accept_s    = 1'b0;
        case (r_state_r)
            R_IDLE: begin
                if (!rst && arvalid) begin
                    rd_accept_s    = 1'b1;
                    r_state_next_s = R_DATA;
                end else begin
                    r_state_next_s = R_IDLE;
                end
            end
            R_DATA: begin
                if (rready) begin
                    r_state_next_s = R_IDLE;
                end else begin
                    r_state_next_s = R_DATA;
                end
            end
            default: r_state_next_s = R_IDLE;
        endcase
    end

    // Read FSM state and captured read data; sampling before the register edge gives pre-write data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_r <= R_IDLE;
            rdata_r   <= {DWIDTH{1'b0}};
            rresp_r   <= RESP_OKAY;
        end else begin
            r_state_r <= r_state_next_s;
            if (rd_accept_s) begin
                if (rd_in_range_s) begin
                    rdata_r <= view_s[rd_idx_s];
                    rresp_r <= RESP_OKAY;
                end else begin
                    rdata_r <= {DWIDTH{1'b0}};
                    rresp_r <= RESP_SLVERR;
                end
            end
        end
    end

    assign awready      = wr_accept_s;
    assign wready       = wr_accept_s;
    assign bvalid       = (w_state_r == W_RESP);
    assign bresp        = bresp_r;
    assign arready      = (r_state_r == R_IDLE) && !rst;
    assign rvalid       = (r_state_r == R_DATA);
    assign rdata        = rdata_r;
    assign rresp        = rresp_r;
    assign cfg_wr_pulse = wr_pulse_r;

endmodule

// File: tb/tb_axil_reg_resp.sv
// Bench for axil_reg_resp: directed scenarios with literal expectations, then randomized
// traffic, all compared every cycle against a transaction-level register model.
module tb_axil_reg_resp;
    localparam int          NREG = 16;
    localparam logic [31:0] VER  = 32'h2017_0001;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
    logic              arvalid = 1'b0, rready = 1'b1;
    logic [31:0]       awaddr = 32'h0, wdata = 32'h0, araddr = 32'h0;
    logic [3:0]        wstrb = 4'h0;
    logic              awready, wready, bvalid, arready, rvalid;
    logic [1:0]        bresp, rresp;
    logic [31:0]       rdata;
    logic [NREG*32-1:0] cfg_regs;
    logic [NREG-1:0]   cfg_wr_pulse;

    axil_reg_resp #(.AWIDTH(32), .DWIDTH(32), .SWIDTH(4), .NREG(NREG), .VERSION(VER)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .cfg_regs(cfg_regs), .cfg_wr_pulse(cfg_wr_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: register array, one pending response per channel.
    logic [31:0]     m_regs [NREG];
    logic            m_bpend, m_rpend;
    logic [1:0]      m_bresp, m_rresp;
    logic [31:0]     m_rdata;
    logic [NREG-1:0] m_pulse;
    logic [511:0]    exp_cfg;

    initial begin : model
        bit wacc, racc, ok;
        int widx;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
                m_bpend = 1'b0; m_rpend = 1'b0; m_bresp = 2'b00; m_rresp = 2'b00;
                m_rdata = 32'h0; m_pulse = '0;
            end else begin
                wacc = !m_bpend && awvalid && wvalid;
                racc = !m_rpend && arvalid;
                if (racc) begin
                    if (araddr < 32'(NREG*4)) begin
                        m_rdata = (araddr / 4 == 0) ? VER : m_regs[araddr / 4];
                        m_rresp = 2'b00;
                    end else begin
                        m_rdata = 32'h0;
                        m_rresp = 2'b10;
                    end
                end
                m_pulse = '0;
                if (wacc) begin
                    ok = (awaddr < 32'(NREG*4)) && (awaddr / 4 != 0);
                    if (ok) begin
                        widx = int'(awaddr / 4);
                        for (int k = 0; k < 4; k++)
                            if (wstrb[k]) m_regs[widx][8*k +: 8] = wdata[8*k +: 8];
                        m_pulse[widx] = 1'b1;
                    end
                    m_bresp = ok ? 2'b00 : 2'b10;
                end
                m_bpend = wacc ? 1'b1 : (m_bpend && !bready);
                m_rpend = racc ? 1'b1 : (m_rpend && !rready);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_cfg = '0;
                exp_cfg[31:0] = VER;
                for (int i = 1; i < NREG; i++) exp_cfg[i*32 +: 32] = m_regs[i];
                chk("awready", awready, !m_bpend && awvalid && wvalid);
                chk("wready", wready, !m_bpend && awvalid && wvalid);
                chk("arready", arready, !m_rpend);
                chk("bvalid", bvalid, m_bpend);
                if (m_bpend) chk("bresp", bresp, m_bresp);
                chk("rvalid", rvalid, m_rpend);
                if (m_rpend) begin
                    chk("rdata", rdata, m_rdata);
                    chk("rresp", rresp, m_rresp);
                end
                chk("cfg_regs", cfg_regs, exp_cfg);
                chk("cfg_wr_pulse", cfg_wr_pulse, m_pulse);
            end
        end
    end

    // Issue a write and return at posedge+1 just after the accept edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        while (!awready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wr_accept", awready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    // Issue a read and return at posedge+1 just after the accept edge.
    task automatic rd(input logic [31:0] a);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rd_accept", arready, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return $urandom;
        return 32'($urandom_range(0, NREG*4 + 7));
    endfunction

    initial begin : stim
        bit aw_taken, ar_taken;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_reg0", cfg_regs[31:0], VER);
        chk("rst_regs", cfg_regs[511:32], 480'h0);
        chk("rst_pulse", cfg_wr_pulse, 16'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arready_after_rst", arready, 1'b1);

        wr(32'h4, 32'hDEADBEEF, 4'hF);
        chk("w1_bvalid", bvalid, 1'b1);
        chk("w1_bresp", bresp, 2'b00);
        chk("w1_reg1", cfg_regs[63:32], 32'hDEADBEEF);
        chk("w1_pulse", cfg_wr_pulse, 16'h0002);
        @(posedge clk); #1;
        chk("w1_pulse_end", cfg_wr_pulse, 16'h0000);
        chk("w1_bvalid_end", bvalid, 1'b0);

        wr(32'h4, 32'h11223344, 4'b0101);
        chk("w2_reg1", cfg_regs[63:32], 32'hDE22BE44);
        @(posedge clk); #1;
        rd(32'h4);
        chk("r1_rvalid", rvalid, 1'b1);
        chk("r1_rdata", rdata, 32'hDE22BE44);
        chk("r1_rresp", rresp, 2'b00);
        @(posedge clk); #1;

        rd(32'h0);
        chk("r0_rdata", rdata, VER);
        chk("r0_rresp", rresp, 2'b00);
        @(posedge clk); #1;
        wr(32'h0, 32'hFFFFFFFF, 4'hF);
        chk("w0_bresp", bresp, 2'b10);
        chk("w0_pulse", cfg_wr_pulse, 16'h0000);
        chk("w0_reg0", cfg_regs[31:0], VER);
        @(posedge clk); #1;
        rd(32'h40);
        chk("roor_rdata", rdata, 32'h0);
        chk("roor_rresp", rresp, 2'b10);
        @(posedge clk); #1;
        wr(32'h40, 32'h55555555, 4'hF);
        chk("woor_bresp", bresp, 2'b10);
        chk("woor_pulse", cfg_wr_pulse, 16'h0000);
        @(posedge clk); #1;
        wr(32'h3F, 32'hCAFEF00D, 4'hF);
        chk("w15_reg", cfg_regs[511:480], 32'hCAFEF00D);
        chk("w15_pulse", cfg_wr_pulse, 16'h8000);
        @(posedge clk); #1;
        wr(32'h4, 32'h0, 4'h0);
        chk("wstrb0_pulse", cfg_wr_pulse, 16'h0002);
        chk("wstrb0_reg1", cfg_regs[63:32], 32'hDE22BE44);
        @(posedge clk); #1;

        // AW ahead of W by five cycles, then bready low for three response cycles.
        bready = 1'b0;
        awaddr = 32'h14; awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("aw_only_ready", awready, 1'b0);
            @(posedge clk); #1;
        end
        wvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF;
        @(negedge clk);
        chk("aw_w_ready", awready, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_bvalid", bvalid, 1'b1);
            chk("hold_bresp", bresp, 2'b00);
            chk("hold_no_accept", awready, 1'b0);
            if (i == 2) bready = 1'b1;
            @(posedge clk); #1;
        end
        chk("hold_bvalid_done", bvalid, 1'b0);
        chk("reaccept_ready", awready, 1'b1);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("hold_reg5", cfg_regs[191:160], 32'h0BADF00D);
        @(posedge clk); #1;

        // Read and write to the same register accepted on the same edge.
        wr(32'h8, 32'h12345678, 4'hF);
        @(posedge clk); #1;
        awaddr = 32'h8; wdata = 32'hAAAA5555; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h8; arvalid = 1'b1;
        @(negedge clk);
        chk("same_awready", awready, 1'b1);
        chk("same_arready", arready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("same_rdata", rdata, 32'h12345678);
        chk("same_reg2", cfg_regs[95:64], 32'hAAAA5555);
        @(posedge clk); #1;
        rd(32'h8);
        chk("same_rdata_after", rdata, 32'hAAAA5555);
        @(posedge clk); #1;

        // Reset while a read response is stalled.
        rready = 1'b0;
        rd(32'h4);
        @(posedge clk); #1;
        chk("stall_rvalid", rvalid, 1'b1);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'hC;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", rvalid, 1'b0);
        chk("mid_rst_reg1", cfg_regs[63:32], 32'h0);
        chk("mid_rst_reg0", cfg_regs[31:0], VER);
        chk("mid_rst_awready", awready, 1'b0);
        chk("mid_rst_arready", arready, 1'b0);
        chk("mid_rst_rdata", rdata, 32'h0);
        awvalid = 1'b0; wvalid = 1'b0; rready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_rvalid", rvalid, 1'b0);
        chk("post_rst_bvalid", bvalid, 1'b0);
        rd(32'h4);
        chk("post_rst_rdata", rdata, 32'h0);
        @(posedge clk); #1;

        // Randomized traffic with valid held until handshake.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            aw_taken = awready;
            ar_taken = arready && arvalid;
            @(posedge clk); #1;
            if (!(awvalid && !aw_taken)) begin
                awvalid = ($urandom_range(0, 99) < 45);
                awaddr  = rand_addr();
            end
            if (!(wvalid && !aw_taken)) begin
                wvalid = ($urandom_range(0, 99) < 45);
                wdata  = $urandom;
                wstrb  = 4'($urandom_range(0, 15));
            end
            if (!(arvalid && !ar_taken)) begin
                arvalid = ($urandom_range(0, 99) < 50);
                araddr  = rand_addr();
            end
            bready = ($urandom_range(0, 99) < 70);
            rready = ($urandom_range(0, 99) < 70);
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
